hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: NUM_REGS, 32, number of architectural registers tracked; REG_AW = clog2(NUM_REGS).
REQ-002 Parameter: LAT_W, 4, width of the long-latency countdown counter.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 id_valid_i  in  1  ID holds a valid instruction.
REQ-006 id_rs1_addr_i  in  REG_AW  ID source register 1.
REQ-007 id_rs2_addr_i  in  REG_AW  ID source register 2.
REQ-008 id_is_rs2_i  in  1  ID instruction reads rs2.
REQ-009 id_rd_addr_i  in  REG_AW  ID destination register.
REQ-010 id_rd_wren_i  in  1  ID instruction writes rd.
REQ-011 id_is_jump_i  in  1  ID holds JAL/JALR/branch.
REQ-012 id_is_long_i  in  1  ID holds a long-latency op (mul/div).
REQ-013 id_long_lat_i  in  LAT_W  cycles the long-latency unit stays occupied.
REQ-014 ex_br_valid_i  in  1  control-flow instruction resolves in EX this cycle.
REQ-015 wb_rd_wren_i  in  1  WB writes a register this cycle.
REQ-016 wb_rd_addr_i  in  REG_AW  WB destination register.
REQ-017 pc_enable_o  out  1  PC register update enable.
REQ-018 id_enable_o  out  1  IF/ID register update enable.
REQ-019 id_flush_o  out  1  ID bubble insert (squash wrong-path fetch).
REQ-020 ex_flush_o  out  1  ID/EX bubble insert.
REQ-021 busy_o  out  NUM_REGS  scoreboard busy bits.
REQ-022 stall_cnt_o  out  32  count of data/structural stall cycles.

Function
REQ-023 issue = id_valid_i & id_enable_o & !id_flush_o; all outputs except busy_o and stall_cnt_o are combinational from state and inputs.
REQ-024 busy[rd] sets on the cycle after an issue with id_rd_wren_i=1 and rd!=0; busy[0] is constantly 0.
REQ-025 busy[wb_rd_addr_i] clears on the cycle after wb_rd_wren_i=1; a set and a clear of the same register in the same cycle leave busy=1.
REQ-026 Data hazard = id_valid_i & (busy[rs1] | (id_is_rs2_i & busy[rs2]) | (id_rd_wren_i & busy[rd])).
REQ-027 Long-latency counter: loads id_long_lat_i on issue of an id_is_long_i op; otherwise decrements when nonzero, saturating at 0.
REQ-028 Structural hazard = id_valid_i & id_is_long_i & (counter != 0).
REQ-029 On a data or structural hazard: pc_enable_o=0, id_enable_o=0, ex_flush_o=1, id_flush_o=0.
REQ-030 Control FSM states: IDLE, RESOLVE; data/structural hazard has priority over the FSM.
REQ-031 IDLE -> RESOLVE on issue of an id_is_jump_i instruction; in that cycle pc_enable_o=0.
REQ-032 In RESOLVE: pc_enable_o=0 and id_flush_o=1 until ex_br_valid_i=1; in that cycle pc_enable_o=1, then -> IDLE.
REQ-033 With no hazard in IDLE: all enables 1, all flushes 0.
REQ-034 ex_br_valid_i in IDLE is ignored.

Reset
REQ-035 While rst_i=1: next-state busy=0, counter=0, FSM=IDLE, stall_cnt_o=0; pc_enable_o=0, id_enable_o=0, id_flush_o=1, ex_flush_o=1.
REQ-036 Reset asserted mid-stall or in RESOLVE abandons the operation; the first post-reset cycle behaves as IDLE with an empty scoreboard.

Configuration
REQ-037 With HAZARD_SCOREBOARD_PERF_EN defined: stall_cnt_o increments (wrapping) each cycle a data or structural hazard stalls.
REQ-038 With HAZARD_SCOREBOARD_PERF_EN undefined: no counter is built; stall_cnt_o is tied to 0.

Verification
REQ-039 Issue rd=5 (wren); ID then holds rs1=5 -> stall (pc_en=0, id_en=0, ex_flush=1) each cycle until WB writes 5; released the cycle after.
REQ-040 busy[5]=1; ID holds rs2=5 with id_is_rs2_i=0 and rs1=0 -> no stall; rd=0 issue -> busy_o unchanged.
REQ-041 Long op issued with lat=3; next long op in ID -> stalled exactly 3 cycles, then issues.
REQ-042 Jump issued -> RESOLVE; id_flush=1, pc_en=0 for 2 cycles; ex_br_valid pulse -> pc_en=1 that cycle, IDLE next.
REQ-043 Same-cycle set and clear of register 7 -> busy[7]=1 after the edge; with PERF_EN, 3 stall cycles -> stall_cnt_o=3, without -> 0.
REQ-044 rst_i pulsed during the REQ-039 stall -> busy_o=0, FSM=IDLE, ID instruction with rs1=5 issues immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and pipeline control for an in-order core: data/structural stalls plus branch-resolve squash.
// Optional stall-cycle performance counter is built when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter  int NUM_REGS = 32,
  parameter  int LAT_W    = 4,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [REG_AW-1:0]   id_rs1_addr_i,
  input  logic [REG_AW-1:0]   id_rs2_addr_i,
  input  logic                id_is_rs2_i,
  input  logic [REG_AW-1:0]   id_rd_addr_i,
  input  logic                id_rd_wren_i,
  input  logic                id_is_jump_i,
  input  logic                id_is_long_i,
  input  logic [LAT_W-1:0]    id_long_lat_i,
  input  logic                ex_br_valid_i,
  input  logic                wb_rd_wren_i,
  input  logic [REG_AW-1:0]   wb_rd_addr_i,
  output logic                pc_enable_o,
  output logic                id_enable_o,
  output logic                id_flush_o,
  output logic                ex_flush_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [31:0]         stall_cnt_o
);

  typedef enum logic {IDLE, RESOLVE} state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;

  logic data_haz;
  logic struct_haz;
  logic stall;
  logic issue;

  always_comb begin
    data_haz   = id_valid_i & (busy_q[id_rs1_addr_i]
                             | (id_is_rs2_i & busy_q[id_rs2_addr_i])
                             | (id_rd_wren_i & busy_q[id_rd_addr_i]));
    struct_haz = id_valid_i & id_is_long_i & (lat_cnt_q != '0);
    stall      = !rst_i & (data_haz | struct_haz);
  end

  // Priority: reset, then hazard stall, then the branch-resolve FSM.
  always_comb begin
    pc_enable_o = 1'b1;
    id_enable_o = 1'b1;
    id_flush_o  = 1'b0;
    ex_flush_o  = 1'b0;
    if (rst_i) begin
      pc_enable_o = 1'b0;
      id_enable_o = 1'b0;
      id_flush_o  = 1'b1;
      ex_flush_o  = 1'b1;
    end else if (stall) begin
      pc_enable_o = 1'b0;
      id_enable_o = 1'b0;
      ex_flush_o  = 1'b1;
    end else if (state_q == RESOLVE) begin
      pc_enable_o = ex_br_valid_i;
      id_flush_o  = 1'b1;
    end else if (id_valid_i && id_is_jump_i) begin
      pc_enable_o = 1'b0;
    end
  end

  assign issue = id_valid_i & id_enable_o & !id_flush_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue && id_is_jump_i) state_d = RESOLVE;
      RESOLVE: if (ex_br_valid_i)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle set wins over a clear so a freshly issued writer stays tracked.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      logic set_bit;
      logic clr_bit;
      assign set_bit    = issue & id_rd_wren_i & (id_rd_addr_i == REG_AW'(gi));
      assign clr_bit    = wb_rd_wren_i & (wb_rd_addr_i == REG_AW'(gi));
      assign busy_d[gi] = set_bit | (busy_q[gi] & !clr_bit);
    end
  end

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if (issue && id_is_long_i) begin
      lat_cnt_d = id_long_lat_i;
    end else if (lat_cnt_q != '0) begin
      lat_cnt_d = lat_cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign busy_o = busy_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: scoreboard set/clear, stalls, long-op occupancy, branch resolve, reset.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, wb_rd_addr_i;
  logic        id_is_rs2_i, id_rd_wren_i, id_is_jump_i, id_is_long_i;
  logic [3:0]  id_long_lat_i;
  logic        ex_br_valid_i, wb_rd_wren_i;
  logic        pc_enable_o, id_enable_o, id_flush_o, ex_flush_o;
  logic [31:0] busy_o, stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_scoreboard dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_is_rs2_i(id_is_rs2_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rd_wren_i(id_rd_wren_i), .id_is_jump_i(id_is_jump_i),
    .id_is_long_i(id_is_long_i), .id_long_lat_i(id_long_lat_i),
    .ex_br_valid_i(ex_br_valid_i), .wb_rd_wren_i(wb_rd_wren_i),
    .wb_rd_addr_i(wb_rd_addr_i), .pc_enable_o(pc_enable_o),
    .id_enable_o(id_enable_o), .id_flush_o(id_flush_o),
    .ex_flush_o(ex_flush_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Control outputs packed as {pc_en, id_en, id_flush, ex_flush}; settle then compare.
  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {28'd0, pc_enable_o, id_enable_o, id_flush_o, ex_flush_o}, {28'd0, exp});
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic is_rs2, input logic [4:0] rd, input logic wren,
                       input logic jump, input logic is_long, input logic [3:0] lat);
    id_valid_i    = v;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    id_is_rs2_i   = is_rs2;
    id_rd_addr_i  = rd;
    id_rd_wren_i  = wren;
    id_is_jump_i  = jump;
    id_is_long_i  = is_long;
    id_long_lat_i = lat;
  endtask

  initial begin
    rst_i = 1'b1;
    ex_br_valid_i = 1'b0;
    wb_rd_wren_i = 1'b0;
    wb_rd_addr_i = 5'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset
    tick();
    chk_ctrl("rst_ctrl", 4'b0011);
    tick();
    chk("rst_busy", busy_o, 32'h0);
    chk("rst_stall", stall_cnt_o, 32'h0);
    rst_i = 1'b0;
    chk_ctrl("idle_ctrl", 4'b1100);

    // RAW on r5 held until WB writes it
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    chk_ctrl("issue_r5", 4'b1100);
    tick();
    chk("busy_r5", busy_o, 32'h20);
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("raw_stall0", 4'b0001);
    tick(); exp_stall++;
    chk_ctrl("raw_stall1", 4'b0001);
    tick(); exp_stall++;
    wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd5;
    chk_ctrl("raw_stall_wb", 4'b0001);
    tick(); exp_stall++;
    wb_rd_wren_i = 1'b0;
    chk("busy_clr_r5", busy_o, 32'h0);
    chk_ctrl("raw_release", 4'b1100);
    chk("stall_cnt3", stall_cnt_o, PERF ? exp_stall : 0);
    tick();

    // rs2 ignored when not read; rd=0 never marks busy
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    chk("busy_r5b", busy_o, 32'h20);
    drive(1, 0, 5, 0, 0, 1, 0, 0, 0);
    chk_ctrl("rs2_unused", 4'b1100);
    tick();
    chk("rd0_nobusy", busy_o, 32'h20);
    drive(1, 0, 5, 1, 0, 0, 0, 0, 0);
    chk_ctrl("rs2_used", 4'b0001);
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    chk_ctrl("waw_stall", 4'b0001);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd5;
    tick();
    wb_rd_wren_i = 1'b0;
    chk("busy_clr_r5b", busy_o, 32'h0);

    // Same-cycle set and clear of r7
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
    wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd7;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_rd_wren_i = 1'b0;
    chk("set_clr_r7", busy_o, 32'h80);
    wb_rd_wren_i = 1'b1;
    tick();
    wb_rd_wren_i = 1'b0;
    chk("clr_r7", busy_o, 32'h0);

    // Long-latency occupancy, lat=3
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3);
    chk_ctrl("long_issue", 4'b1100);
    tick();
    chk_ctrl("long_st1", 4'b0001);
    tick(); exp_stall++;
    chk_ctrl("long_st2", 4'b0001);
    tick(); exp_stall++;
    chk_ctrl("long_st3", 4'b0001);
    tick(); exp_stall++;
    chk_ctrl("long_issue2", 4'b1100);
    chk("stall_cnt6", stall_cnt_o, PERF ? exp_stall : 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("short_no_st", 4'b1100);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // Jump: RESOLVE until the branch resolves
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    chk_ctrl("jump_issue", 4'b0100);
    tick();
    drive(1, 0, 0, 0, 9, 1, 0, 0, 0);
    chk_ctrl("resolve1", 4'b0110);
    tick();
    chk("wrongpath_nob", busy_o, 32'h0);
    chk_ctrl("resolve2", 4'b0110);
    tick();
    ex_br_valid_i = 1'b1;
    chk_ctrl("resolve_done", 4'b1110);
    tick();
    ex_br_valid_i = 1'b0;
    chk("wrongpath_nob2", busy_o, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("back_idle", 4'b1100);
    ex_br_valid_i = 1'b1;
    chk_ctrl("br_idle_ign", 4'b1100);
    tick();
    ex_br_valid_i = 1'b0;
    chk_ctrl("still_idle", 4'b1100);
    tick();

    // Reset during a RAW stall
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("pre_rst_st", 4'b0001);
    tick();
    rst_i = 1'b1;
    chk_ctrl("rst_mid", 4'b0011);
    tick();
    rst_i = 1'b0;
    chk("rst_mid_busy", busy_o, 32'h0);
    chk("rst_mid_cnt", stall_cnt_o, 32'h0);
    chk_ctrl("post_rst_iss", 4'b1100);
    tick();

    // Reset while in RESOLVE
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("resolve_pre", 4'b0110);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_ctrl("rst_resolve", 4'b1100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
